// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game stages: slot width, FSM encoding
// and the 16-bit Galois LFSR step used by every stage that needs randomness.
package mole_pkg;

    localparam int unsigned SLOT_W            = 4;
    localparam int unsigned DEFAULT_NUM_SLOTS = 8;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StGen   = 2'd1;
    localparam state_t StWrite = 2'd2;

    // Right-shifting Galois step: feed the dropped LSB back through the taps.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with the seed on reset.
module lfsr16
    import mole_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] seed_i,
    output logic [15:0] q_o
);

    logic [15:0] q_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= seed_i;
        end else begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mole_pattern_gen.sv
// Builds a NUM_SLOTS x 4-bit mole-position pattern from LFSR candidates and hands
// it to the game core with a one-cycle write_enable pulse.
module mole_pattern_gen
    import mole_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
    parameter int unsigned KEY_MAX   = 8,
    parameter bit          NO_REPEAT = 1'b1,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned RETRY_MAX = 15
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        game_start_i,
    input  logic                        gen_req_i,
    output logic [SLOT_W*NUM_SLOTS-1:0] data_out_o,
    output logic                        write_enable_o,
    output logic                        busy_o,
    output logic [6:0]                  pattern_count_o
);

    localparam int unsigned DataW    = SLOT_W * NUM_SLOTS;
    localparam int unsigned SlotIdxW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned RetryW   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [SlotIdxW-1:0] LastSlot   = SlotIdxW'(NUM_SLOTS - 1);
    localparam logic [RetryW-1:0]   RetryLimit = RetryW'(RETRY_MAX);
    localparam logic [SLOT_W:0]     KeyMaxExt  = (SLOT_W + 1)'(KEY_MAX);
    localparam logic [6:0]          CountMax   = 7'd127;

    logic [15:0]         lfsr;
    logic [SLOT_W-1:0]   cand;

    state_t              state_q, state_d;
    logic [SlotIdxW-1:0] slot_q, slot_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [DataW-1:0]    stage_q, stage_d;
    logic [DataW-1:0]    data_q, data_d;
    logic [6:0]          count_q, count_d;
    logic                pending_q, pending_d;
    logic                game_start_q;

    logic                req;
    logic [SLOT_W-1:0]   prev_val;
    logic [SLOT_W:0]     fb_sum;
    logic [SLOT_W-1:0]   fb_val;
    logic                reject;
    logic                accept;
    logic [SLOT_W-1:0]   slot_val;

    lfsr16 u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .seed_i  (SEED),
        .q_o     (lfsr)
    );

    assign cand = lfsr[SLOT_W-1:0];
    assign req  = gen_req_i | (game_start_i & ~game_start_q);

    // Value already staged for the slot before the current one; slot 0 sees 0.
    always_comb begin
        prev_val = '0;
        for (int i = 1; i < NUM_SLOTS; i++) begin
            if (slot_q == SlotIdxW'(i)) begin
                prev_val = stage_q[(i-1)*SLOT_W +: SLOT_W];
            end
        end
    end

    assign fb_sum = {1'b0, prev_val} + 1'b1;
    assign fb_val = (fb_sum > KeyMaxExt) ? '0 : fb_sum[SLOT_W-1:0];
    assign reject = ({1'b0, cand} > KeyMaxExt) ||
                    (NO_REPEAT && (slot_q != '0) && (cand == prev_val));

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        retry_d   = retry_q;
        stage_d   = stage_q;
        data_d    = data_q;
        count_d   = count_q;
        pending_d = pending_q;
        accept    = 1'b0;
        slot_val  = cand;

        case (state_q)
            StIdle: begin
                if (req || pending_q) begin
                    state_d   = StGen;
                    slot_d    = '0;
                    retry_d   = '0;
                    pending_d = 1'b0;
                end
            end
            StGen: begin
                if (req) begin
                    pending_d = 1'b1;
                end
                if (!reject) begin
                    accept = 1'b1;
                end else if (retry_q == RetryLimit) begin
                    accept   = 1'b1;
                    slot_val = fb_val;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
                if (accept) begin
                    retry_d = '0;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (slot_q == SlotIdxW'(i)) begin
                            stage_d[i*SLOT_W +: SLOT_W] = slot_val;
                        end
                    end
                    // Output register loads on entry to WRITE so data is valid with the pulse.
                    if (slot_q == LastSlot) begin
                        state_d = StWrite;
                        data_d  = stage_d;
                        if (count_q != CountMax) begin
                            count_d = count_q + 7'd1;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                if (req) begin
                    pending_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            retry_q      <= '0;
            stage_q      <= '0;
            data_q       <= '0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            game_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            retry_q      <= retry_d;
            stage_q      <= stage_d;
            data_q       <= data_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            game_start_q <= game_start_i;
        end
    end

    assign data_out_o      = data_q;
    assign write_enable_o  = (state_q == StWrite);
    assign busy_o          = (state_q != StIdle);
    assign pattern_count_o = count_q;

endmodule

// File: tb/tb_mole_pattern_gen.sv
// Directed bench for mole_pattern_gen: three instances (default, no-reject, KEY_MAX=1)
// checked against a bench-side LFSR and pattern model.
module tb_mole_pattern_gen;
    import mole_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  gen_req;
    logic [2:0]  game_start;
    wire  [31:0] dout_w [3];
    wire  [6:0]  cnt_w  [3];
    wire         we_w   [3];
    wire         busy_w [3];

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    mole_pattern_gen dut0 (
        .clk_i(clk), .reset_i(reset), .game_start_i(game_start[0]), .gen_req_i(gen_req[0]),
        .data_out_o(dout_w[0]), .write_enable_o(we_w[0]), .busy_o(busy_w[0]),
        .pattern_count_o(cnt_w[0])
    );

    mole_pattern_gen #(.KEY_MAX(15), .NO_REPEAT(1'b0)) dut1 (
        .clk_i(clk), .reset_i(reset), .game_start_i(game_start[1]), .gen_req_i(gen_req[1]),
        .data_out_o(dout_w[1]), .write_enable_o(we_w[1]), .busy_o(busy_w[1]),
        .pattern_count_o(cnt_w[1])
    );

    mole_pattern_gen #(.KEY_MAX(1)) dut2 (
        .clk_i(clk), .reset_i(reset), .game_start_i(game_start[2]), .gen_req_i(gen_req[2]),
        .data_out_o(dout_w[2]), .write_enable_o(we_w[2]), .busy_o(busy_w[2]),
        .pattern_count_o(cnt_w[2])
    );

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lstep_n(input logic [15:0] v, input int n);
        logic [15:0] r = v;
        for (int i = 0; i < n; i++) r = lstep(r);
        return r;
    endfunction

    // Reference LFSR tracking the DUT's free-running generator cycle by cycle.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lstep(m_lfsr);
    end

    // Pattern model: l0 is the LFSR value in the first GEN cycle; cycles = GEN cycles used.
    task automatic model_gen(input logic [15:0] l0, input int key_max, input bit no_rep,
                             output logic [31:0] pat, output int cycles);
        logic [15:0] l = l0;
        int slot = 0, retry = 0, c, prev, fb;
        pat = '0;
        cycles = 0;
        while (slot < 8) begin
            c = int'(l[3:0]);
            prev = (slot == 0) ? 0 : int'(pat[(slot-1)*4 +: 4]);
            if (c > key_max || (no_rep && slot > 0 && c == prev)) begin
                if (retry == 15) begin
                    fb = prev + 1;
                    if (fb > key_max) fb = 0;
                    pat[slot*4 +: 4] = 4'(fb);
                    slot++;
                    retry = 0;
                end else begin
                    retry++;
                end
            end else begin
                pat[slot*4 +: 4] = 4'(c);
                slot++;
                retry = 0;
            end
            l = lstep(l);
            cycles++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        gen_req    = '0;
        game_start = '0;
        reset      = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // mode 0: gen_req pulse, 1: game_start held high, 2: both in the same cycle.
    task automatic run_req(input int idx, input int mode, input int len, output int nwe,
                           output int wk, output logic [31:0] wd, output logic [15:0] lt);
        lt = m_lfsr;
        if (mode != 1) gen_req[idx] = 1'b1;
        if (mode != 0) game_start[idx] = 1'b1;
        nwe = 0;
        wk  = -1;
        wd  = '0;
        for (int k = 1; k <= len; k++) begin
            tick();
            gen_req[idx] = 1'b0;
            if (we_w[idx]) begin
                nwe++;
                if (wk < 0) begin
                    wk = k;
                    wd = dout_w[idx];
                end
            end
        end
    endtask

    task automatic test_reset();
        gen_req    = '0;
        game_start = '0;
        reset      = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tests++;
        if (dut0.lfsr !== 16'hACE1) begin
            fails++;
            $display("FAIL reset_lfsr: got %h expected %h", dut0.lfsr, 16'hACE1);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (dout_w[i] !== 32'h0) begin
                fails++;
                $display("FAIL reset_data[%0d]: got %h expected 0", i, dout_w[i]);
            end
            tests++;
            if (we_w[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_we[%0d]: got %b expected 0", i, we_w[i]);
            end
            tests++;
            if (busy_w[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy_w[i]);
            end
            tests++;
            if (cnt_w[i] !== 7'd0) begin
                fails++;
                $display("FAIL reset_count[%0d]: got %0d expected 0", i, cnt_w[i]);
            end
        end
        tick();
        tests++;
        if (dut0.lfsr !== 16'hE270) begin
            fails++;
            $display("FAIL lfsr_step: got %h expected %h", dut0.lfsr, 16'hE270);
        end
    endtask

    task automatic test_single();
        int nwe, wk, c;
        logic [31:0] wd, exp;
        logic [15:0] lt;
        bit legal;
        do_reset();
        run_req(0, 1, 150, nwe, wk, wd, lt);
        game_start[0] = 1'b0;
        model_gen(lstep(lt), 8, 1'b1, exp, c);
        tests++;
        if (nwe !== 1) begin
            fails++;
            $display("FAIL single_pulses: got %0d expected 1", nwe);
        end
        tests++;
        if (wk !== c + 1) begin
            fails++;
            $display("FAIL single_latency: got %0d expected %0d", wk, c + 1);
        end
        tests++;
        if (wd !== exp) begin
            fails++;
            $display("FAIL single_data: got %h expected %h", wd, exp);
        end
        legal = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (wd[i*4 +: 4] > 4'd8) legal = 1'b0;
            if (i > 0 && wd[i*4 +: 4] == wd[(i-1)*4 +: 4]) legal = 1'b0;
        end
        tests++;
        if (!legal) begin
            fails++;
            $display("FAIL single_legal: got %h expected nibbles <=8 and no adjacent repeat", wd);
        end
        tests++;
        if (cnt_w[0] !== 7'd1) begin
            fails++;
            $display("FAIL single_count: got %0d expected 1", cnt_w[0]);
        end
    endtask

    task automatic test_no_reject();
        int nwe, wk;
        logic [31:0] wd, exp;
        logic [15:0] lt, l;
        do_reset();
        run_req(1, 0, 20, nwe, wk, wd, lt);
        l   = lt;
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            l = lstep(l);
            exp[i*4 +: 4] = l[3:0];
        end
        tests++;
        if (nwe !== 1) begin
            fails++;
            $display("FAIL noreject_pulses: got %0d expected 1", nwe);
        end
        tests++;
        if (wk !== 9) begin
            fails++;
            $display("FAIL noreject_latency: got %0d expected 9", wk);
        end
        tests++;
        if (wd !== exp) begin
            fails++;
            $display("FAIL noreject_data: got %h expected %h", wd, exp);
        end
        tests++;
        if (busy_w[1] !== 1'b0) begin
            fails++;
            $display("FAIL noreject_idle_busy: got %b expected 0", busy_w[1]);
        end
    endtask

    task automatic test_pending();
        int c1, c2, w1, w2, nwe, k1, k2;
        logic [31:0] p1, p2, d1, d2;
        logic [15:0] lt;
        do_reset();
        lt = m_lfsr;
        model_gen(lstep(lt), 8, 1'b1, p1, c1);
        w1 = c1 + 1;
        model_gen(lstep_n(lt, w1 + 2), 8, 1'b1, p2, c2);
        w2 = w1 + 2 + c2;
        gen_req[0] = 1'b1;
        nwe = 0; k1 = -1; k2 = -1; d1 = '0; d2 = '0;
        for (int k = 1; k <= w2 + 40; k++) begin
            tick();
            gen_req[0] = (k == 3 || k == 5);
            if (we_w[0]) begin
                nwe++;
                if (nwe == 1) begin k1 = k; d1 = dout_w[0]; end
                if (nwe == 2) begin k2 = k; d2 = dout_w[0]; end
            end
        end
        tests++;
        if (nwe !== 2) begin
            fails++;
            $display("FAIL pending_pulses: got %0d expected 2", nwe);
        end
        tests++;
        if (k1 !== w1 || d1 !== p1) begin
            fails++;
            $display("FAIL pending_first: got cyc %0d data %h expected cyc %0d data %h",
                     k1, d1, w1, p1);
        end
        tests++;
        if (k2 !== w2 || d2 !== p2) begin
            fails++;
            $display("FAIL pending_second: got cyc %0d data %h expected cyc %0d data %h",
                     k2, d2, w2, p2);
        end
        tests++;
        if (d1 === d2) begin
            fails++;
            $display("FAIL pending_distinct: got %h twice expected two different patterns", d1);
        end
        tests++;
        if (cnt_w[0] !== 7'd2) begin
            fails++;
            $display("FAIL pending_count: got %0d expected 2", cnt_w[0]);
        end
    endtask

    task automatic test_simultaneous();
        int nwe, wk, c;
        logic [31:0] wd, exp;
        logic [15:0] lt;
        do_reset();
        run_req(0, 2, 150, nwe, wk, wd, lt);
        game_start[0] = 1'b0;
        model_gen(lstep(lt), 8, 1'b1, exp, c);
        tests++;
        if (nwe !== 1 || wk !== c + 1 || wd !== exp) begin
            fails++;
            $display("FAIL simultaneous: got %0d pulses cyc %0d data %h expected 1 cyc %0d data %h",
                     nwe, wk, wd, c + 1, exp);
        end
        tests++;
        if (cnt_w[0] !== 7'd1) begin
            fails++;
            $display("FAIL simultaneous_count: got %0d expected 1", cnt_w[0]);
        end
    endtask

    task automatic test_reset_mid_gen();
        int saw, nwe, wk, c;
        logic [31:0] wd, exp;
        logic [15:0] lt;
        do_reset();
        gen_req[0] = 1'b1;
        saw = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            gen_req[0] = 1'b0;
            if (we_w[0]) saw++;
            if (k == 2) begin
                tests++;
                if (busy_w[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL midgen_busy: got %b expected 1", busy_w[0]);
                end
            end
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (we_w[0]) saw++;
        end
        reset = 1'b0;
        tests++;
        if (saw !== 0) begin
            fails++;
            $display("FAIL midgen_no_write: got %0d pulses expected 0", saw);
        end
        tests++;
        if (dout_w[0] !== 32'h0 || busy_w[0] !== 1'b0 || cnt_w[0] !== 7'd0) begin
            fails++;
            $display("FAIL midgen_cleared: got data %h busy %b count %0d expected 0 0 0",
                     dout_w[0], busy_w[0], cnt_w[0]);
        end
        tests++;
        if (dut0.state_q !== StIdle) begin
            fails++;
            $display("FAIL midgen_state: got %0d expected %0d", dut0.state_q, StIdle);
        end
        run_req(0, 0, 150, nwe, wk, wd, lt);
        model_gen(lstep(16'hACE1), 8, 1'b1, exp, c);
        tests++;
        if (nwe !== 1 || wd !== exp) begin
            fails++;
            $display("FAIL midgen_repeat: got %0d pulses data %h expected 1 data %h",
                     nwe, wd, exp);
        end
    endtask

    task automatic test_fallback();
        int nwe, wk, c;
        logic [31:0] wd, exp;
        logic [15:0] lt;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            run_req(2, 0, 150, nwe, wk, wd, lt);
            model_gen(lstep(lt), 1, 1'b1, exp, c);
            tests++;
            if (nwe !== 1 || wk !== c + 1) begin
                fails++;
                $display("FAIL fallback_timing[%0d]: got %0d pulses cyc %0d expected 1 cyc %0d",
                         r, nwe, wk, c + 1);
            end
            tests++;
            if (wd !== exp) begin
                fails++;
                $display("FAIL fallback_data[%0d]: got %h expected %h", r, wd, exp);
            end
            tests++;
            if (wd !== 32'h10101010 && wd !== 32'h01010101) begin
                fails++;
                $display("FAIL fallback_alternate[%0d]: got %h expected 10101010 or 01010101",
                         r, wd);
            end
            tests++;
            if (cnt_w[2] !== 7'(r + 1)) begin
                fails++;
                $display("FAIL fallback_count[%0d]: got %0d expected %0d", r, cnt_w[2], r + 1);
            end
        end
    endtask

    task automatic test_saturation();
        int nwe, wk, exp_cnt;
        logic [31:0] wd;
        logic [15:0] lt;
        do_reset();
        for (int i = 1; i <= 130; i++) begin
            run_req(1, 0, 11, nwe, wk, wd, lt);
            exp_cnt = (i > 127) ? 127 : i;
            tests++;
            if (cnt_w[1] !== 7'(exp_cnt)) begin
                fails++;
                $display("FAIL saturation_count[%0d]: got %0d expected %0d", i, cnt_w[1], exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_reject();
        test_pending();
        test_simultaneous();
        test_reset_mid_gen();
        test_fallback();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/mole_pattern_gen.md
Name: mole_pattern_gen

Overview:
- Produces the 32-bit mole-position pattern for the whack-a-mole game core: eight 4-bit slots, each one a keypad/LED index.
- Sits directly upstream of the game core. Its data_out/write_enable pair drives the core's data_in/write_enable.
- Generates a fresh pattern when the game starts, and again each time the core pulses change_answer after its last slot.
- Randomness comes from a free-running 16-bit LFSR, so player timing perturbs which patterns appear.

Parameters:
- NUM_SLOTS, 8: nibbles per pattern. data_out width is 4*NUM_SLOTS.
- KEY_MAX, 8: largest legal slot value; legal slots are 0..KEY_MAX. Range 1..15.
- NO_REPEAT, 1: when 1, adjacent slots must differ.
- SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- RETRY_MAX, 15: rejected candidates allowed per slot before the fallback value is used.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- game_start, input, 1: generation request, level-tolerant, rising-edge detected.
- gen_req, input, 1: generation request; the core's change_answer, 1-cycle pulse.
- data_out, output, 4*NUM_SLOTS: last completed pattern. Slot 0 is in [3:0].
- write_enable, output, 1: 1-cycle pulse; data_out is valid in the same cycle.
- busy, output, 1: high in GEN and WRITE states.
- pattern_count, output, 7: completed patterns, saturating at 127.

Behaviour:
- Reset (synchronous, active-high):
  - lfsr <= SEED; state <= IDLE; data_out <= 0; write_enable <= 0; busy <= 0; pattern_count <= 0.
  - Staging register, slot index, retry counter, pending flag and game_start edge register all clear to 0.
- Reset mid-GEN or mid-WRITE aborts the pattern. No write_enable is emitted.
- LFSR:
  - Galois, 16-bit, taps 16'hB400, shifts right.
  - Advances every cycle in every state, including IDLE.
  - Candidate value = lfsr[3:0], sampled before the advance.
- Request:
  - req = gen_req OR (game_start AND NOT game_start_q).
  - In IDLE, req moves to GEN next cycle, clearing slot and retry.
  - req during GEN or WRITE sets pending (one deep; extra requests are dropped).
  - pending is consumed as a req in the first IDLE cycle.
- GEN, one candidate per cycle:
  - Reject if cand > KEY_MAX, or if NO_REPEAT=1, slot>0 and cand == previous slot value.
  - Reject: retry++, slot unchanged.
  - Accept: stage[slot] <= cand; slot++; retry <= 0.
  - Fallback: if retry == RETRY_MAX and cand is rejected, write fb = prev+1 instead, where fb wraps to 0 if > KEY_MAX. For slot 0, prev = 0. Counts as an accept.
  - Accept in slot NUM_SLOTS-1 moves to WRITE.
- WRITE (1 cycle):
  - data_out <= stage; write_enable = 1; pattern_count++ unless it is already 127.
  - Next state is IDLE.
- Latency: with zero rejects, write_enable is high exactly NUM_SLOTS+1 cycles after the request edge (9 for defaults). Each reject adds 1 cycle.
- data_out holds its value between WRITE pulses, so the core may sample it late.
- Previous-slot comparison uses the staged current pattern only. There is no cross-pattern repeat check.
- Simultaneous game_start edge and gen_req count as one request.

Decomposition:
- Shared package mole_pkg:
  - state enum {IDLE, GEN, WRITE}
  - LFSR_TAPS = 16'hB400
  - SLOT_W = 4
  - default NUM_SLOTS
- Sub-module lfsr16:
  - Ports: clk, reset, seed, q.
  - Free-running; reused by later game stages.

Test Plan:
- Reset check: hold reset 3 cycles, then release. data_out=0, write_enable=0, busy=0, pattern_count=0; lfsr equals 16'hACE1 on the first cycle after release.
- Default single request: game_start rises. Exactly one write_enable pulse. All eight nibbles ≤ 8, no two adjacent equal, pattern_count=1. The bench reference-model LFSR predicts the exact data_out.
- No-reject latency: KEY_MAX=15, NO_REPEAT=0, gen_req pulse at cycle t. write_enable at t+9 only. data_out equals the 8 successive lfsr[3:0] values.
- Pending request: second gen_req 3 cycles after the first. Two write_enable pulses with distinct data_out values; a third gen_req inside the same window is dropped (pattern_count=2).
- Reset mid-GEN: gen_req, then reset at t+4. No write_enable, data_out=0, state IDLE. The next request yields a pattern identical to a post-reset first pattern.
- Fallback and saturation:
  - KEY_MAX=1, NO_REPEAT=1: data_out alternates 0/1 per slot, and every nibble is ≤ 1.
  - 130 requests: pattern_count stops at 127.
